// File: rtl/test_status_port_pkg.sv
// test_status_port_pkg: register map, state encodings and failure codes of the self-check device
package test_status_port_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;
    localparam logic [1:0]  REG_STATUS   = 2'd0;
    localparam logic [1:0]  REG_EXPECT   = 2'd1;
    localparam logic [1:0]  REG_ACTUAL   = 2'd2;
    localparam logic [1:0]  REG_DONE     = 2'd3;
    localparam logic [31:0] FAIL_TIMEOUT = 32'hDEAD_0000;
    localparam logic [31:0] FAIL_NOCHECK = 32'hFFFF_0000;
endpackage

// File: rtl/test_status_port_watchdog_counter.sv
// watchdog_counter: counts enabled cycles since the last clear and flags the final one
module watchdog_counter #(
    parameter logic [19:0] TIMEOUT = 20'd100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [19:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 20'd1;
    end

    assign expired = enable && !clear && cnt == TIMEOUT - 20'd1;
endmodule

// File: rtl/test_status_port.sv
// test_status_port: memory-mapped self-check device comparing expected/actual pairs with a watchdog
module test_status_port
    import test_status_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter logic [19:0] TIMEOUT   = 20'd100000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_write,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             hit,
    output logic             done,
    output logic             pass,
    output logic [31:0]      fail_code,
    output logic [CNT_W-1:0] check_count
);
    state_t           state_q, state_d;
    logic [31:0]      off, expect_q;
    logic [1:0]       idx;
    logic             fail_flag, active, wr, is_exp, is_act, is_done, mismatch, expired;
    logic [CNT_W-1:0] count_inc;

    assign off       = addr - BASE_ADDR;
    assign hit       = off < 32'd16;
    assign idx       = off[3:2];
    assign active    = state_q == ST_IDLE || state_q == ST_RUN;
    assign wr        = mem_write && hit && active;
    assign is_exp    = wr && idx == REG_EXPECT;
    assign is_act    = wr && idx == REG_ACTUAL;
    assign is_done   = wr && idx == REG_DONE;
    assign count_inc = &check_count ? check_count : check_count + 1'b1;
    assign mismatch  = is_act && wdata != expect_q && !fail_flag;
    assign done      = state_q == ST_PASS || state_q == ST_FAIL || state_q == ST_TIMEOUT;
    assign pass      = state_q == ST_PASS;
    assign rdata     = !hit ? 32'd0 :
                       idx == REG_STATUS ? {27'd0, state_q, pass, done} :
                       idx == REG_EXPECT ? expect_q : 32'd0;

    watchdog_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wr),
        .enable  (state_q == ST_RUN),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // a DONE write outranks watchdog expiry; any window write clears the watchdog anyway
    always_comb begin
        state_d = state_q;
        if (is_done)
            state_d = fail_flag ? ST_FAIL : (check_count != '0 ? ST_PASS : ST_FAIL);
        else if (wr)
            state_d = ST_RUN;
        else if (expired)
            state_d = ST_TIMEOUT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expect_q    <= '0;
            check_count <= '0;
            fail_code   <= '0;
            fail_flag   <= 1'b0;
        end else begin
            if (is_exp)
                expect_q <= wdata;
            if (is_act)
                check_count <= count_inc;
            if (mismatch) begin
                fail_flag <= 1'b1;
                fail_code <= {16'(count_inc), 16'h0};
            end
            if (is_done && !fail_flag && check_count == '0)
                fail_code <= FAIL_NOCHECK;
            if (expired)
                fail_code <= FAIL_TIMEOUT;
        end
    end
endmodule

// File: tb/tb_test_status_port.sv
// tb_test_status_port: directed checks of the self-check device protocol, watchdog and reset
module tb_test_status_port;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0, reset = 1'b1, mem_write = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata, fail_code;
    logic        hit, done, pass;
    logic [15:0] check_count;
    int          vectors = 0, miscompares = 0;

    test_status_port #(.BASE_ADDR(BASE), .TIMEOUT(20'd50), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .hit         (hit),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .check_count (check_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic status(input string tag, input logic [31:0] exp);
        addr = BASE;
        #1 check(tag, rdata, exp);
    endtask

    initial begin
        #3;
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cnt", check_count, 0);
        check("rst_code", fail_code, 0);
        status("rst_status", 32'h0);
        @(negedge clk);
        reset = 1'b0;

        addr = BASE + 32'h10;
        #1 check("miss_hi_hit", hit, 0);
        check("miss_hi_rdata", rdata, 0);
        addr = BASE - 32'h4;
        #1 check("miss_lo_hit", hit, 0);
        wr(BASE + 32'h10, 32'h1);
        wr(BASE - 32'h4, 32'h1);
        status("miss_idle", 32'h0);
        addr = BASE + 32'hC;
        #1 check("hit_top", hit, 1);

        wr(BASE + 32'h4, 32'd9);
        addr = BASE + 32'h4;
        #1 check("rd_expect", rdata, 9);
        status("run_status", 32'h4);

        do_reset();
        wr(BASE + 32'h4, 32'd5);
        wr(BASE + 32'h8, 32'd5);
        wr(BASE + 32'h4, 32'd7);
        wr(BASE + 32'h8, 32'd7);
        check("pass_pre_done", done, 0);
        wr(BASE + 32'hC, 32'd0);
        check("pass_done", done, 1);
        check("pass_pass", pass, 1);
        check("pass_cnt", check_count, 2);
        check("pass_code", fail_code, 0);
        status("pass_status", 32'hB);
        wr(BASE + 32'h8, 32'd99);
        check("pass_frozen_cnt", check_count, 2);
        check("pass_frozen_code", fail_code, 0);

        do_reset();
        wr(BASE + 32'h4, 32'd5);
        wr(BASE + 32'h8, 32'd6);
        check("fail_first_code", fail_code, 32'h0001_0000);
        check("fail_first_done", done, 0);
        wr(BASE + 32'h4, 32'd1);
        wr(BASE + 32'h8, 32'd2);
        wr(BASE + 32'hC, 32'd0);
        check("fail_done", done, 1);
        check("fail_pass", pass, 0);
        check("fail_code", fail_code, 32'h0001_0000);
        check("fail_cnt", check_count, 2);
        status("fail_status", 32'hD);
        #2 reset = 1'b1;
        #1 check("async_done", done, 0);
        check("async_code", fail_code, 0);
        check("async_cnt", check_count, 0);
        @(negedge clk);
        reset = 1'b0;

        wr(BASE + 32'h4, 32'd3);
        wr(BASE + 32'hC, 32'd0);
        check("nochk_done", done, 1);
        check("nochk_pass", pass, 0);
        check("nochk_code", fail_code, 32'hFFFF_0000);
        wr(BASE + 32'h8, 32'd3);
        check("nochk_cnt", check_count, 0);

        do_reset();
        wr(BASE + 32'h4, 32'd0);
        repeat (40) @(negedge clk);
        wr(BASE + 32'h4, 32'd0);
        repeat (49) @(negedge clk);
        check("wdog_not_yet", done, 0);
        @(negedge clk);
        check("wdog_done", done, 1);
        check("wdog_code", fail_code, 32'hDEAD_0000);
        status("wdog_status", 32'h11);

        do_reset();
        repeat (3) begin
            wr(BASE + 32'h4, 32'd1);
            wr(BASE + 32'h8, 32'd1);
        end
        check("mid_cnt", check_count, 3);
        #2 reset = 1'b1;
        #1 check("mid_rst_cnt", check_count, 0);
        check("mid_rst_done", done, 0);
        status("mid_rst_status", 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wr(BASE + 32'h4, 32'd5);
        wr(BASE + 32'h8, 32'd5);
        wr(BASE + 32'hC, 32'd0);
        check("fresh_pass", pass, 1);
        check("fresh_cnt", check_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
